// File: rtl/cordic_fix2float.sv
// Sequential signed fixed-point (Q(IN_W-FRAC_BITS).FRAC_BITS) to IEEE-754 single converter.
// Optional round-to-nearest-even in PACK via `define FIX2FLOAT_ROUND_EN; default truncates.
module cordic_fix2float #(
    parameter int IN_W      = 32,
    parameter int FRAC_BITS = 30
) (
    input  logic            clk,
    input  logic            reset_n,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [IN_W-1:0] in_data,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [31:0]     out_data
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_NORM,
        S_PACK,
        S_HOLD
    } state_e;

    localparam int KW       = $clog2(IN_W);
    localparam int EXP_BIAS = 127 + (IN_W - 1 - FRAC_BITS);
    localparam int EXP_MIN  = EXP_BIAS - (IN_W - 1);
`ifdef FIX2FLOAT_ROUND_EN
    localparam int EXP_MAX  = EXP_BIAS + 1;
    localparam int MIN_W    = 26;
`else
    localparam int EXP_MAX  = EXP_BIAS;
    localparam int MIN_W    = 24;
`endif

    // Every reachable exponent must be a normal float; denormal/inf are never built.
    generate
        if (IN_W < MIN_W || EXP_MIN < 1 || EXP_MAX > 254) begin : g_param_check
            $error("cordic_fix2float: IN_W/FRAC_BITS give exponent outside 1..254 or too few bits");
        end
    endgenerate

    state_e          state_q, state_d;
    logic            sign_q, sign_d;
    logic            zero_q, zero_d;
    logic [IN_W-1:0] mag_q, mag_d;
    logic [KW-1:0]   k_q, k_d;
    logic [31:0]     out_data_q, out_data_d;

    logic [7:0]      exp_w;
    logic [22:0]     mant_w;
    logic [30:0]     body_w;

    // State register.
    // NOTE: sequential state is written with non-blocking assignments only, so every
    // register samples the pre-edge values and simulation matches the synthesised flops.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state_q <= S_IDLE;
        else          state_q <= state_d;
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_IDLE: if (in_valid)                           state_d = S_NORM;
            S_NORM: if (mag_q == '0 || mag_q[IN_W-1])       state_d = S_PACK;
            S_PACK:                                         state_d = S_HOLD;
            S_HOLD: if (out_ready)                          state_d = S_IDLE;
            default:                                        state_d = S_IDLE;
        endcase
    end

    // Output decode: handshake flags follow the registered state directly.
    always_comb begin
        in_ready  = (state_q == S_IDLE);
        out_valid = (state_q == S_HOLD);
        out_data  = out_data_q;
    end

    // Field assembly: k counts the left shifts applied, so it lowers the exponent.
    always_comb begin
        exp_w  = 8'(EXP_BIAS - int'(k_q));
        mant_w = mag_q[IN_W-2 -: 23];
`ifdef FIX2FLOAT_ROUND_EN
        begin
            logic guard_w, sticky_w, round_up_w;
            guard_w    = mag_q[IN_W-25];
            sticky_w   = |mag_q[IN_W-26:0];
            round_up_w = guard_w && (sticky_w || mant_w[0]);
            // A carry out of the mantissa ripples into the exponent field by construction.
            body_w     = {exp_w, mant_w} + 31'(round_up_w);
        end
`else
        body_w = {exp_w, mant_w};
`endif
    end

    // Datapath next-state.
    // NOTE: every variable gets its hold value first, so no path through the case
    // leaves one unassigned and no latch is inferred.
    always_comb begin
        sign_d     = sign_q;
        zero_d     = zero_q;
        mag_d      = mag_q;
        k_d        = k_q;
        out_data_d = out_data_q;
        unique case (state_q)
            S_IDLE: begin
                if (in_valid) begin
                    sign_d = in_data[IN_W-1];
                    // Most-negative input wraps to 1<<(IN_W-1), which is its true magnitude.
                    mag_d  = in_data[IN_W-1] ? (~in_data) + IN_W'(1) : in_data;
                    k_d    = '0;
                    zero_d = 1'b0;
                end
            end
            S_NORM: begin
                if (mag_q == '0) begin
                    zero_d = 1'b1;
                end else if (!mag_q[IN_W-1]) begin
                    mag_d = mag_q << 1;
                    k_d   = k_q + KW'(1);
                end
            end
            S_PACK: begin
                out_data_d = zero_q ? 32'h0000_0000 : {sign_q, body_w};
            end
            default: ;
        endcase
    end

    // NOTE: the reset clears every datapath register so an aborted conversion
    // leaves nothing behind and out_data reads zero straight out of reset.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sign_q     <= 1'b0;
            zero_q     <= 1'b0;
            mag_q      <= '0;
            k_q        <= '0;
            out_data_q <= '0;
        end else begin
            sign_q     <= sign_d;
            zero_q     <= zero_d;
            mag_q      <= mag_d;
            k_q        <= k_d;
            out_data_q <= out_data_d;
        end
    end

endmodule

// File: tb/tb_cordic_fix2float.sv
// Directed table-driven bench for cordic_fix2float (Q2.30 defaults); expected floats and
// latencies are hand-derived, including FIX2FLOAT_ROUND_EN-dependent rows.
module tb_cordic_fix2float;

    logic        clk;
    logic        reset_n;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_data;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_data;

    int checks = 0;
    int errors = 0;

    localparam int LIMIT = 60;

    typedef struct {
        string       name;
        logic [31:0] din;
        logic [31:0] dout;
        int          lat;
    } vec_t;

    vec_t vecs[$];

    cordic_fix2float #(.IN_W(32), .FRAC_BITS(30)) dut (
        .clk      (clk),
        .reset_n  (reset_n),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_data  (in_data),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_data (out_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp_v);
        checks++;
        if (act !== exp_v) begin
            errors++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp_v);
        end
    endtask

    // Called just after the accepting edge; counts edges until out_valid rises.
    task automatic wait_result(input string name, input logic [31:0] exp_data, input int exp_lat);
        int n = 0;
        for (int i = 1; i <= LIMIT; i++) begin
            @(posedge clk);
            #1;
            if (out_valid) begin
                n = i;
                break;
            end
        end
        if (n == 0) begin
            checks++;
            errors++;
            $display("FAIL %s timeout: out_valid never rose within %0d edges, expected %0d", name, LIMIT, exp_lat);
        end else begin
            check({name, " latency"}, 32'(n), 32'(exp_lat));
            check({name, " data"}, out_data, exp_data);
        end
    endtask

    task automatic run_one(input string name, input logic [31:0] din, input logic [31:0] dout, input int lat);
        @(negedge clk);
        check({name, " idle in_ready"}, 32'(in_ready), 32'd1);
        in_valid = 1'b1;
        in_data  = din;
        @(posedge clk);
        #1;
        @(negedge clk);
        in_valid = 1'b0;
        in_data  = 32'hDEAD_BEEF;
        wait_result(name, dout, lat);
        @(posedge clk);
        #1;
        check({name, " out_valid drop"}, 32'(out_valid), 32'd0);
        check({name, " in_ready back"}, 32'(in_ready), 32'd1);
    endtask

    initial begin
        vecs.push_back('{"+1.0",        32'h4000_0000, 32'h3F80_0000, 3});
        vecs.push_back('{"-1.0",        32'hC000_0000, 32'hBF80_0000, 3});
        vecs.push_back('{"zero",        32'h0000_0000, 32'h0000_0000, 2});
        vecs.push_back('{"-2.0",        32'h8000_0000, 32'hC000_0000, 2});
        vecs.push_back('{"2^-30",       32'h0000_0001, 32'h3080_0000, 33});
        vecs.push_back('{"+0.5",        32'h2000_0000, 32'h3F00_0000, 4});
        vecs.push_back('{"+1.5",        32'h6000_0000, 32'h3FC0_0000, 3});
        vecs.push_back('{"-0.25",       32'hF000_0000, 32'hBE80_0000, 5});
        vecs.push_back('{"3*2^-30",     32'h0000_0003, 32'h3140_0000, 32});
        vecs.push_back('{"tie even",    32'h4000_0040, 32'h3F80_0000, 3});
`ifdef FIX2FLOAT_ROUND_EN
        vecs.push_back('{"max pos",     32'h7FFF_FFFF, 32'h4000_0000, 3});
        vecs.push_back('{"tie odd",     32'h4000_00C0, 32'h3F80_0002, 3});
        vecs.push_back('{"above half",  32'h4000_0041, 32'h3F80_0001, 3});
`else
        vecs.push_back('{"max pos",     32'h7FFF_FFFF, 32'h3FFF_FFFF, 3});
        vecs.push_back('{"tie odd",     32'h4000_00C0, 32'h3F80_0001, 3});
        vecs.push_back('{"above half",  32'h4000_0041, 32'h3F80_0000, 3});
`endif

        reset_n   = 1'b0;
        in_valid  = 1'b0;
        in_data   = 32'h0;
        out_ready = 1'b1;
        #12;
        check("reset in_ready", 32'(in_ready), 32'd1);
        check("reset out_valid", 32'(out_valid), 32'd0);
        check("reset out_data", out_data, 32'h0);
        @(negedge clk);
        reset_n = 1'b1;

        foreach (vecs[i]) run_one(vecs[i].name, vecs[i].din, vecs[i].dout, vecs[i].lat);

        // Back-pressure: result held for 10 cycles, new request ignored until IDLE.
        @(negedge clk);
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_data   = 32'h4000_0000;
        @(posedge clk);
        #1;
        @(negedge clk);
        in_data = 32'h2000_0000;
        wait_result("hold conv", 32'h3F80_0000, 3);
        for (int c = 0; c < 10; c++) begin
            @(posedge clk);
            #1;
            check("hold out_valid", 32'(out_valid), 32'd1);
            check("hold out_data", out_data, 32'h3F80_0000);
            check("hold in_ready", 32'(in_ready), 32'd0);
        end
        @(negedge clk);
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        check("release out_valid", 32'(out_valid), 32'd0);
        check("release in_ready", 32'(in_ready), 32'd1);
        @(posedge clk);
        #1;
        check("next accept in_ready", 32'(in_ready), 32'd0);
        @(negedge clk);
        in_valid = 1'b0;
        wait_result("after hold", 32'h3F00_0000, 4);
        @(posedge clk);
        #1;
        check("after hold drop", 32'(out_valid), 32'd0);

        // Reset in the middle of a long normalisation.
        @(negedge clk);
        in_valid = 1'b1;
        in_data  = 32'h0000_0001;
        @(posedge clk);
        #1;
        @(negedge clk);
        in_valid = 1'b0;
        repeat (5) @(posedge clk);
        @(negedge clk);
        reset_n = 1'b0;
        #1;
        check("midreset in_ready", 32'(in_ready), 32'd1);
        check("midreset out_valid", 32'(out_valid), 32'd0);
        check("midreset out_data", out_data, 32'h0);
        @(posedge clk);
        @(negedge clk);
        reset_n = 1'b1;
        run_one("post-reset +1.0", 32'h4000_0000, 32'h3F80_0000, 3);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
